// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Shares one single-port, byte-addressed RAM between the instruction-fetch
//   requester and the load/store requester. One access is granted per cycle.
//   Data has priority unless fetch has waited STARVE_LIMIT consecutive data
//   grants. Byte/half stores become a two-cycle read-modify-write of the
//   aligned word. Sub-word loads are sign- or zero-extended.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   if_req_*/if_addr   fetch request handshake and byte address
//   if_rsp_*           one-cycle fetch response (word, misalignment error)
//   d_req_*/d_*        load/store request handshake, address, size, data
//   d_rsp_*            one-cycle data response (extended load data, error)
//   mem_addr           word-aligned RAM address
//   mem_write_en       RAM write strobe (written on the clock edge)
//   mem_wdata          RAM write word
//   mem_dout           combinational RAM read of the word at mem_addr
module riscv_mem_arbiter #(
    parameter int WORD_LENGTH  = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_req_valid,
    output logic                   if_req_ready,
    input  logic [WORD_LENGTH-1:0] if_addr,
    output logic                   if_rsp_valid,
    output logic [WORD_LENGTH-1:0] if_rsp_inst,
    output logic                   if_rsp_err,
    input  logic                   d_req_valid,
    output logic                   d_req_ready,
    input  logic [WORD_LENGTH-1:0] d_addr,
    input  logic                   d_we,
    input  logic [1:0]             d_size,
    input  logic                   d_unsigned,
    input  logic [WORD_LENGTH-1:0] d_wdata,
    output logic                   d_rsp_valid,
    output logic [WORD_LENGTH-1:0] d_rsp_rdata,
    output logic                   d_rsp_err,
    output logic [WORD_LENGTH-1:0] mem_addr,
    output logic                   mem_write_en,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    input  logic [WORD_LENGTH-1:0] mem_dout
);

    typedef enum logic [0:0] {
        IDLE,
        RMW_WR
    } state_t;

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         starve_cnt, starve_cnt_d;
    logic [WORD_LENGTH-1:0]   rmw_addr, rmw_data;

    logic                     grant_if, grant_d;
    logic                     if_misaligned, d_misaligned;
    logic                     d_word_store, d_sub_store, d_load_ok;
    logic [4:0]               lane_shift;
    logic [WORD_LENGTH-1:0]   load_shifted, load_ext;
    logic [WORD_LENGTH-1:0]   lane_mask, merged;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    always_comb begin
        d_misaligned = 1'b1;
        lane_shift   = '0;
        case (d_size)
            2'b00: begin
                d_misaligned = 1'b0;
                lane_shift   = {d_addr[1:0], 3'b000};
            end
            2'b01: begin
                d_misaligned = d_addr[0];
                lane_shift   = {d_addr[1], 4'b0000};
            end
            2'b10:   d_misaligned = |d_addr[1:0];
            default: d_misaligned = 1'b1;
        endcase
    end

    assign if_misaligned = |if_addr[1:0];

    // Load path: move the addressed lane to bit 0, then extend.
    assign load_shifted = mem_dout >> lane_shift;

    always_comb begin
        load_ext  = load_shifted;
        lane_mask = '1;
        case (d_size)
            2'b00: begin
                load_ext  = {{(WORD_LENGTH-8){~d_unsigned & load_shifted[7]}},
                             load_shifted[7:0]};
                lane_mask = WORD_LENGTH'(8'hFF) << lane_shift;
            end
            2'b01: begin
                load_ext  = {{(WORD_LENGTH-16){~d_unsigned & load_shifted[15]}},
                             load_shifted[15:0]};
                lane_mask = WORD_LENGTH'(16'hFFFF) << lane_shift;
            end
            default: begin
                load_ext  = load_shifted;
                lane_mask = '1;
            end
        endcase
    end

    // Store path: only the addressed lanes of the current RAM word change.
    assign merged = (mem_dout & ~lane_mask) | ((d_wdata << lane_shift) & lane_mask);

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
    always_comb begin
        grant_d  = (state_q == IDLE) && d_req_valid &&
                   !(if_req_valid && (starve_cnt == CNT_MAX));
        grant_if = (state_q == IDLE) && if_req_valid && !grant_d;
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    assign d_word_store = grant_d && d_we && !d_misaligned && (d_size == 2'b10);
    assign d_sub_store  = grant_d && d_we && !d_misaligned && (d_size != 2'b10);
    assign d_load_ok    = grant_d && !d_we && !d_misaligned;

    // The RMW write cycle grants nobody, so it neither counts nor clears
    // unless fetch is idle.
    always_comb begin
        starve_cnt_d = starve_cnt;
        if (!if_req_valid || grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_d && (starve_cnt != CNT_MAX)) begin
            starve_cnt_d = starve_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state and RAM port drive
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mem_addr     = '0;
        mem_write_en = 1'b0;
        mem_wdata    = '0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    mem_addr = {d_addr[WORD_LENGTH-1:2], 2'b00};
                    if (d_word_store) begin
                        mem_write_en = 1'b1;
                        mem_wdata    = d_wdata;
                    end
                    if (d_sub_store) begin
                        state_d = RMW_WR;
                    end
                end else if (grant_if) begin
                    mem_addr = {if_addr[WORD_LENGTH-1:2], 2'b00};
                end
            end
            RMW_WR: begin
                mem_addr     = rmw_addr;
                mem_write_en = 1'b1;
                mem_wdata    = rmw_data;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt   <= '0;
            rmw_addr     <= '0;
            rmw_data     <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_inst  <= '0;
            if_rsp_err   <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rsp_rdata  <= '0;
            d_rsp_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt   <= starve_cnt_d;

            if_rsp_valid <= grant_if;
            if_rsp_err   <= grant_if && if_misaligned;
            if_rsp_inst  <= (grant_if && !if_misaligned) ? mem_dout : '0;

            // Sub-word stores respond from RMW_WR instead of the accept cycle.
            d_rsp_valid  <= (grant_d && !d_sub_store) || (state_q == RMW_WR);
            d_rsp_err    <= grant_d && d_misaligned;
            d_rsp_rdata  <= d_load_ok ? load_ext : '0;

            if (d_sub_store) begin
                rmw_addr <= {d_addr[WORD_LENGTH-1:2], 2'b00};
                rmw_data <= merged;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
//   Directed bench for riscv_mem_arbiter with a small combinational-read RAM
//   attached to the memory port. Expected values are hand-computed constants.
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic        if_rsp_err;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_addr;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:63];

    int compared;
    int mismatched;

    riscv_mem_arbiter #(
        .WORD_LENGTH (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_addr     (if_addr),
        .if_rsp_valid(if_rsp_valid),
        .if_rsp_inst (if_rsp_inst),
        .if_rsp_err  (if_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_addr      (d_addr),
        .d_we        (d_we),
        .d_size      (d_size),
        .d_unsigned  (d_unsigned),
        .d_wdata     (d_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_rdata (d_rsp_rdata),
        .d_rsp_err   (d_rsp_err),
        .mem_addr    (mem_addr),
        .mem_write_en(mem_write_en),
        .mem_wdata   (mem_wdata),
        .mem_dout    (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dout = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write_en) ram[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch issued at a negedge; response checked one cycle later.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_inst, input logic exp_err);
        if_req_valid = 1'b1;
        if_addr      = addr;
        #1;
        chk({tag, ".if_ready"}, {31'b0, if_req_ready}, 32'd1);
        chk({tag, ".d_ready"},  {31'b0, d_req_ready},  32'd0);
        chk({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        if_req_valid = 1'b0;
        chk({tag, ".rsp_valid"}, {31'b0, if_rsp_valid}, 32'd1);
        chk({tag, ".rsp_inst"},  if_rsp_inst, exp_inst);
        chk({tag, ".rsp_err"},   {31'b0, if_rsp_err}, {31'b0, exp_err});
    endtask

    // Single-cycle data access: load, word store or misaligned access.
    task automatic d_op(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_we, input logic [31:0] exp_rdata, input logic exp_err);
        d_req_valid = 1'b1;
        d_we        = we;
        d_size      = size;
        d_unsigned  = uns;
        d_addr      = addr;
        d_wdata     = wdata;
        #1;
        chk({tag, ".d_ready"},  {31'b0, d_req_ready},  32'd1);
        chk({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".mem_we"},   {31'b0, mem_write_en}, {31'b0, exp_we});
        if (exp_we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
        @(negedge clk);
        d_req_valid = 1'b0;
        chk({tag, ".rsp_valid"}, {31'b0, d_rsp_valid}, 32'd1);
        chk({tag, ".rsp_rdata"}, d_rsp_rdata, exp_rdata);
        chk({tag, ".rsp_err"},   {31'b0, d_rsp_err}, {31'b0, exp_err});
    endtask

    // Byte/half store: write in N+1, response in N+2.
    task automatic sub_store(input string tag, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_word);
        d_req_valid = 1'b1;
        d_we        = 1'b1;
        d_size      = size;
        d_unsigned  = 1'b0;
        d_addr      = addr;
        d_wdata     = wdata;
        #1;
        chk({tag, ".d_ready"}, {31'b0, d_req_ready},  32'd1);
        chk({tag, ".mem_we0"}, {31'b0, mem_write_en}, 32'd0);
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        chk({tag, ".mem_we1"},   {31'b0, mem_write_en}, 32'd1);
        chk({tag, ".mem_wdata"}, mem_wdata, exp_word);
        chk({tag, ".mem_addr"},  mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".rsp_early"}, {31'b0, d_rsp_valid},  32'd0);
        @(negedge clk);
        chk({tag, ".rsp_valid"}, {31'b0, d_rsp_valid}, 32'd1);
        chk({tag, ".rsp_rdata"}, d_rsp_rdata, 32'd0);
        chk({tag, ".rsp_err"},   {31'b0, d_rsp_err}, 32'd0);
        chk({tag, ".ram"},       ram[addr[7:2]], exp_word);
    endtask

    initial begin
        logic [0:9] arb_a;
        logic [0:4] arb_b;

        compared     = 0;
        mismatched   = 0;
        rst_n        = 1'b0;
        if_req_valid = 1'b0;
        if_addr      = '0;
        d_req_valid  = 1'b0;
        d_addr       = '0;
        d_we         = 1'b0;
        d_size       = 2'b10;
        d_unsigned   = 1'b0;
        d_wdata      = '0;
        for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
        ram[4] <= 32'h00A00093;
        ram[8] <= 32'h8001F0FF;

        #2;
        chk("rst.if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
        chk("rst.d_rsp_valid",  {31'b0, d_rsp_valid},  32'd0);
        chk("rst.mem_we",       {31'b0, mem_write_en}, 32'd0);
        chk("rst.mem_addr",     mem_addr, 32'd0);
        chk("rst.d_rsp_rdata",  d_rsp_rdata, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Fetch
        fetch("fetch10", 32'h10, 32'h00A00093, 1'b0);
        fetch("fetch12", 32'h12, 32'h0, 1'b1);
        @(negedge clk);
        chk("fetch.pulse", {31'b0, if_rsp_valid}, 32'd0);

        // Loads over 0x8001F0FF
        d_op("lb20",  1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0);
        d_op("lbu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b0, 32'h000000F0, 1'b0);
        d_op("lh22",  1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFF8001, 1'b0);
        d_op("lhu22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'h00008001, 1'b0);
        d_op("lw20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h8001F0FF, 1'b0);
        d_op("lw21",  1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 1'b0, 32'h0, 1'b1);
        d_op("lsz3",  1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b1);
        d_op("sw22",  1'b1, 2'b10, 1'b0, 32'h22, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        d_op("sh21",  1'b1, 2'b01, 1'b0, 32'h21, 32'h1234, 1'b0, 32'h0, 1'b1);
        chk("mis.ram", ram[8], 32'h8001F0FF);

        // Sub-word stores with a fetch waiting through the write cycle
        ram[8] <= 32'h11223344;
        @(negedge clk);
        d_req_valid = 1'b1;
        d_we        = 1'b1;
        d_size      = 2'b00;
        d_addr      = 32'h21;
        d_wdata     = 32'h000000AB;
        #1;
        chk("sb.d_ready", {31'b0, d_req_ready}, 32'd1);
        @(negedge clk);
        d_req_valid  = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = 32'h10;
        #1;
        chk("sb.mem_we",    {31'b0, mem_write_en}, 32'd1);
        chk("sb.mem_wdata", mem_wdata, 32'h1122AB44);
        chk("sb.if_ready",  {31'b0, if_req_ready}, 32'd0);
        chk("sb.d_ready1",  {31'b0, d_req_ready},  32'd0);
        @(negedge clk);
        chk("sb.rsp_valid", {31'b0, d_rsp_valid}, 32'd1);
        #1;
        chk("sb.if_grant",  {31'b0, if_req_ready}, 32'd1);
        @(negedge clk);
        if_req_valid = 1'b0;
        chk("sb.if_rsp",    if_rsp_inst, 32'h00A00093);
        chk("sb.ram",       ram[8], 32'h1122AB44);

        sub_store("sh22", 2'b01, 32'h22, 32'h0000BEEF, 32'hBEEFAB44);

        // Reset during the RMW write cycle
        d_req_valid = 1'b1;
        d_we        = 1'b1;
        d_size      = 2'b00;
        d_addr      = 32'h40;
        d_wdata     = 32'h5A;
        #1;
        chk("rstrmw.d_ready", {31'b0, d_req_ready}, 32'd1);
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        chk("rstrmw.we_before", {31'b0, mem_write_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstrmw.we_after", {31'b0, mem_write_en}, 32'd0);
        chk("rstrmw.addr",     mem_addr, 32'd0);
        @(negedge clk);
        chk("rstrmw.ram",   ram[16], 32'h0);
        chk("rstrmw.rsp0",  {31'b0, d_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstrmw.rsp1",  {31'b0, d_rsp_valid}, 32'd0);
        chk("rstrmw.ifrsp", {31'b0, if_rsp_valid}, 32'd0);
        d_op("rstrmw.first", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'hBEEFAB44, 1'b0);

        // Arbitration with both requesters held valid (1 = data grant)
        arb_a = 10'b1111011110;
        arb_b = 5'b11110;
        if_req_valid = 1'b1;
        if_addr      = 32'h10;
        d_req_valid  = 1'b1;
        d_we         = 1'b0;
        d_size       = 2'b10;
        d_addr       = 32'h20;
        for (int unsigned i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("arb_a%0d.d", i),  {31'b0, d_req_ready},  {31'b0, arb_a[i]});
            chk($sformatf("arb_a%0d.if", i), {31'b0, if_req_ready}, {31'b0, ~arb_a[i]});
            @(negedge clk);
        end
        for (int unsigned i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("arb_pre%0d.d", i), {31'b0, d_req_ready}, 32'd1);
            @(negedge clk);
        end
        if_req_valid = 1'b0;
        #1;
        chk("arb_drop.d", {31'b0, d_req_ready}, 32'd1);
        @(negedge clk);
        if_req_valid = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("arb_b%0d.d", i),  {31'b0, d_req_ready},  {31'b0, arb_b[i]});
            chk($sformatf("arb_b%0d.if", i), {31'b0, if_req_ready}, {31'b0, ~arb_b[i]});
            @(negedge clk);
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        @(negedge clk);

        // Back-to-back word store then load of the same address
        d_op("b2b.sw", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0);
        d_op("b2b.lw", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares the single-port, byte-addressed RISC-V RAM between the instruction-fetch requester and the load/store requester using valid/ready handshakes. It grants one access per cycle, with data priority bounded by a fetch-starvation limit. It converts byte and halfword stores into a two-cycle read-modify-write of the aligned word, and sign- or zero-extends sub-word loads. It sits between the core's fetch/LSU stages and the RAM's data port, which has a combinational read and a write on the clock edge.

## Interface
- WORD_LENGTH, 32, data/address width; the logic is specified for 32.
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending; must be ≥1.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address
- if_rsp_valid  out  1  one-cycle fetch response pulse
- if_rsp_inst  out  32  fetched word
- if_rsp_err  out  1  fetch address misaligned
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_addr  in  32  data byte address
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and is treated as misaligned
- d_unsigned  in  1  zero-extend loads when 1
- d_wdata  in  32  store data, right-aligned
- d_rsp_valid  out  1  one-cycle data response pulse
- d_rsp_rdata  out  32  extended load data; 0 for stores and errors
- d_rsp_err  out  1  misaligned or illegal-size access
- mem_addr  out  32  word-aligned RAM address
- mem_write_en  out  1  RAM write strobe
- mem_wdata  out  32  RAM write word
- mem_dout  in  32  combinational RAM read of the word at mem_addr

## Operation
- States: IDLE and RMW_WR.
- **Grant in IDLE**
  - If only one requester is valid, it is granted.
  - If both are valid, data is granted unless starve_cnt == STARVE_LIMIT, in which case fetch is granted.
  - if_req_ready and d_req_ready are combinational from the valids. At most one is high.
  - Both readies are low in RMW_WR.
- **Starvation counter (starve_cnt)**
  - Increments on a data grant while if_req_valid is high.
  - Clears on a fetch grant, or on any cycle with if_req_valid low.
  - Saturates at STARVE_LIMIT.
- **Memory addressing**
  - mem_addr = {addr[31:2], 2'b00} of the granted request.
  - mem_addr is 0 and mem_write_en is 0 when nothing is granted.
- **Fetch**
  - Registers mem_dout into if_rsp_inst.
  - If if_addr[1:0] != 0: if_rsp_err = 1, if_rsp_inst = 0.
- **Load**
  - Byte: sh = 8*addr[1:0]. Half: sh = 16*addr[1]. Word: sh = 0.
  - Shifts mem_dout right by sh, then sign- or zero-extends to 32 bits per d_unsigned.
  - Registers the result into d_rsp_rdata.
- **Word store**
  - Asserts mem_write_en in the accept cycle, with mem_wdata = d_wdata.
- **Byte/half store (read-modify-write)**
  - In the accept cycle, merges d_wdata into the affected lanes of mem_dout and registers the merged word, its address and the response flags.
  - Moves to RMW_WR.
  - In RMW_WR, drives the registered address and word with mem_write_en = 1, then returns to IDLE.
- **Misalignment**
  - A misaligned access is half with addr[0] = 1, word with addr[1:0] != 0, or d_size = 11.
  - It is still accepted. It never asserts mem_write_en and responds with d_rsp_err = 1 and d_rsp_rdata = 0.

## Timing
- **Reset values:** all outputs are 0, state = IDLE, starve_cnt = 0.
  - Reset mid-RMW aborts the write: mem_write_en drops asynchronously and no response is issued.
- **Latency, for acceptance in cycle N:**
  - Fetch, load, word store and error: response pulse in N+1.
  - Byte/half store: write in N+1, response in N+2.
- Response pulses last exactly one cycle and have no backpressure.
- The requester may issue its next request in the cycle its response is valid.
- During RMW_WR, a request pending from either side waits, and its valid must be held.
- The RMW write cycle does not count toward starve_cnt.
- Requesters must hold addr, size and data stable while valid is high and ready is low.

## Test plan
- **Reset:** assert rst_n = 0 mid-RMW.
  - mem_write_en falls immediately.
  - All rsp_valid are 0 after reset.
  - The first grant after reset goes to the lone valid requester.
- **Fetch:** preload word 0x00A00093 at 0x10 and fetch 0x10.
  - if_rsp_inst = 0x00A00093 one cycle after the handshake.
  - Fetch 0x12: if_rsp_err = 1.
- **Loads:** with word 0x8001F0FF at 0x20:
  - LB 0x20 → 0xFFFFFFFF.
  - LBU 0x21 → 0x000000F0.
  - LH 0x22 → 0xFFFF8001.
  - LHU 0x22 → 0x00008001.
  - LW 0x21 → err = 1, no write.
- **Sub-word store:** SB 0xAB to 0x21 over 0x11223344.
  - N+1: mem_write_en = 1, mem_wdata = 0x1122AB44.
  - N+2: d_rsp_valid = 1.
  - Both readies are low in N+1.
  - SH 0xBEEF to 0x22 gives 0xBEEFAB44.
- **Arbitration with STARVE_LIMIT = 4:** hold both valids.
  - Grant sequence is D, D, D, D, F, D, D, D, D, F.
  - If fetch drops its valid mid-sequence, the counter clears.
- **Back-to-back:** word store immediately followed by a load of the same address.
  - The load returns the newly written data.
  - Accepts occur in consecutive cycles.
